// File: rtl/astir_sync_pkg.sv
// Shared constants, FSM state type and timing-code helper for the
// astir embedded-sync encoder.
package astir_sync_pkg;

    // Timing-code preamble bytes.
    localparam logic [7:0] PRE_FF = 8'hFF;
    localparam logic [7:0] PRE_00 = 8'h00;

    // Blanking fill pattern: FILL_A on even positions, FILL_B on odd.
    localparam logic [7:0] FILL_A = 8'h80;
    localparam logic [7:0] FILL_B = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EAV    = 3'd1,
        ST_HBLANK = 3'd2,
        ST_SAV    = 3'd3,
        ST_ACTIVE = 3'd4
    } enc_state_e;

    // XY status byte: {1, F, V, H, P3, P2, P1, P0} with the protection bits.
    function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/astir_tx_timing.sv
// Horizontal/vertical position counters for the sync encoder. Counters run
// only while i_run is high and sit at zero otherwise.
module astir_tx_timing #(
    parameter  int H_ACTIVE = 1280,
    parameter  int H_BLANK  = 272,
    parameter  int V_ACTIVE = 480,
    parameter  int V_BLANK  = 45,
    localparam int LINE_LEN = H_ACTIVE + H_BLANK + 8,
    localparam int V_TOTAL  = V_BLANK + V_ACTIVE,
    localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1,
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_h_wrap,
    output logic          o_frame_wrap,
    output logic          o_v_blank
);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BL   = VW'(V_BLANK);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    // Advance h every byte, v on each h wrap; hold both at zero when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_run) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + VW'(1);
                end
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
                r_v_cnt <= r_v_cnt;
            end
        end else begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end
    end

    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_h_wrap     = (r_h_cnt == H_LAST);
    assign o_frame_wrap = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign o_v_blank    = (r_v_cnt < V_BL);

endmodule

// File: rtl/astir_sync_encoder.sv
// BT.656-style embedded-sync transmitter: emits EAV/SAV timing codes,
// blanking fill and active pixel bytes pulled from a FWFT pixel FIFO.
// Optional feature macro: ASTIR_ENC_FIELD_EN (toggle F at every frame wrap).
module astir_sync_encoder
    import astir_sync_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 272,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] pix_data,
    input  logic       pix_empty,
    output logic       pix_rd,
    output logic [7:0] data_out,
    output logic       frame_start,
    output logic       underrun,
    input  logic       underrun_clr
);

    localparam int LINE_LEN = H_ACTIVE + H_BLANK + 8;
    localparam int V_TOTAL  = V_BLANK + V_ACTIVE;
    localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Last h position of each region within a line.
    localparam logic [HW-1:0] EAV_LAST  = HW'(3);
    localparam logic [HW-1:0] HBL_LAST  = HW'(3 + H_BLANK);
    localparam logic [HW-1:0] SAV_FIRST = HW'(4 + H_BLANK);
    localparam logic [HW-1:0] SAV_LAST  = HW'(7 + H_BLANK);

    enc_state_e    r_state;
    logic [7:0]    r_data;
    logic          r_fs;
    logic          r_underrun;

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_frame_wrap;
    logic          w_v_blank;
    logic          w_run;
    logic          w_field;
    logic [1:0]    w_sav_pos;
    logic [7:0]    w_fill;
    logic [7:0]    w_byte;
    logic          w_fs;
    logic          w_pix_rd;
    logic          w_urun_evt;

    assign w_run = (r_state != ST_IDLE);

    astir_tx_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) u_timing (
        .i_clk        (clock_in),
        .i_rst        (reset),
        .i_run        (w_run),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_h_wrap     (w_h_wrap),
        .o_frame_wrap (w_frame_wrap),
        .o_v_blank    (w_v_blank)
    );

`ifdef ASTIR_ENC_FIELD_EN
    logic r_field;

    // Field flag flips at every frame wrap so successive frames alternate F.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_field <= 1'b0;
        end else if (w_run && w_frame_wrap) begin
            r_field <= ~r_field;
        end else begin
            r_field <= r_field;
        end
    end

    assign w_field = r_field;
`else
    assign w_field = 1'b0;
`endif

    // Region starts are even, so the fill phase is simply h_cnt[0].
    assign w_fill    = w_h_cnt[0] ? FILL_B : FILL_A;
    assign w_sav_pos = w_h_cnt[1:0] - SAV_FIRST[1:0];

    // Select the byte for the current position and the FIFO pop / underrun event.
    always_comb begin
        w_byte     = w_fill;
        w_fs       = 1'b0;
        w_pix_rd   = 1'b0;
        w_urun_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_byte = FILL_A;
            end
            ST_EAV: begin
                w_fs = (w_h_cnt == HW'(0)) && (w_v_cnt == VW'(0));
                case (w_h_cnt[1:0])
                    2'd0:    w_byte = PRE_FF;
                    2'd1:    w_byte = PRE_00;
                    2'd2:    w_byte = PRE_00;
                    2'd3:    w_byte = xy_code(w_field, w_v_blank, 1'b1);
                    default: w_byte = FILL_A;
                endcase
            end
            ST_HBLANK: begin
                w_byte = w_fill;
            end
            ST_SAV: begin
                case (w_sav_pos)
                    2'd0:    w_byte = PRE_FF;
                    2'd1:    w_byte = PRE_00;
                    2'd2:    w_byte = PRE_00;
                    2'd3:    w_byte = xy_code(w_field, w_v_blank, 1'b0);
                    default: w_byte = FILL_A;
                endcase
            end
            ST_ACTIVE: begin
                if (!w_v_blank) begin
                    if (!pix_empty) begin
                        w_byte   = pix_data;
                        w_pix_rd = 1'b1;
                    end else begin
                        // Line timing never stalls: keep counting and emit fill.
                        w_byte     = w_fill;
                        w_urun_evt = 1'b1;
                    end
                end else begin
                    w_byte = w_fill;
                end
            end
            default: begin
                w_byte = FILL_A;
            end
        endcase
    end

    // Region FSM plus registered stream, frame pulse and sticky underrun.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_data     <= FILL_A;
            r_fs       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_data     <= w_byte;
            r_fs       <= w_fs;
            r_underrun <= w_urun_evt | (r_underrun & ~underrun_clr);
            case (r_state)
                ST_IDLE: begin
                    r_state <= enable ? ST_EAV : ST_IDLE;
                end
                ST_EAV: begin
                    if (w_h_cnt == EAV_LAST) begin
                        r_state <= (H_BLANK == 0) ? ST_SAV : ST_HBLANK;
                    end else begin
                        r_state <= ST_EAV;
                    end
                end
                ST_HBLANK: begin
                    if (w_h_cnt == HBL_LAST) begin
                        r_state <= ST_SAV;
                    end else begin
                        r_state <= ST_HBLANK;
                    end
                end
                ST_SAV: begin
                    if (w_h_cnt == SAV_LAST) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_state <= ST_SAV;
                    end
                end
                ST_ACTIVE: begin
                    if (w_h_wrap) begin
                        // enable is only honoured at a frame boundary.
                        if (w_frame_wrap && !enable) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_EAV;
                        end
                    end else begin
                        r_state <= ST_ACTIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_rd      = w_pix_rd;
    assign data_out    = r_data;
    assign frame_start = r_fs;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_astir_sync_encoder.sv
// Directed testbench for astir_sync_encoder with a 20-byte line, 3-line frame.
module tb_astir_sync_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] pix_data;
    logic       pix_empty;
    logic       pix_rd;
    logic [7:0] data_out;
    logic       frame_start;
    logic       underrun;
    logic       underrun_clr;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_q [$];
    logic       pop_s;

    // Hand-written frame for H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, V_BLANK=1, F=0.
    logic [7:0] exp_frame [60] = '{
        8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
        8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10,
        8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
        8'h00, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
        8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
        8'h00, 8'h80, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10
    };

    astir_sync_encoder #(
        .H_ACTIVE (8),
        .H_BLANK  (4),
        .V_ACTIVE (2),
        .V_BLANK  (1)
    ) dut (
        .clock_in     (clk),
        .reset        (reset),
        .enable       (enable),
        .pix_data     (pix_data),
        .pix_empty    (pix_empty),
        .pix_rd       (pix_rd),
        .data_out     (data_out),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    // Field flag expected for a given frame number since reset.
    function automatic logic fr_f(input int fnum);
        logic odd;
        odd = ((fnum % 2) == 1);
`ifdef ASTIR_ENC_FIELD_EN
        return odd;
`else
        return odd & 1'b0;
`endif
    endfunction

    // Expected byte at frame position idx with field f, pixel offset, or fill in pixel slots.
    function automatic logic [7:0] exp_byte(input int idx, input logic f,
                                            input logic [7:0] ofs, input logic fill_pix);
        logic [7:0] b;
        int         p;
        p = idx % 60;
        b = exp_frame[p];
        if (f && ((p % 20) == 3 || (p % 20) == 11)) begin
            case (b)
                8'hB6:   b = 8'hF1;
                8'hAB:   b = 8'hEC;
                8'h9D:   b = 8'hDA;
                8'h80:   b = 8'hC7;
                default: b = b;
            endcase
        end
        if ((p >= 32 && p < 40) || p >= 52) begin
            if (fill_pix) b = ((p % 2) == 1) ? 8'h10 : 8'h80;
            else          b = b + ofs;
        end
        return b;
    endfunction

    task automatic refresh_fifo();
        pix_empty = (fifo_q.size() == 0);
        pix_data  = pix_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic load_fifo(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
        refresh_fifo();
    endtask

    // One clock: sample pop request mid-cycle, then step past the edge.
    task automatic tick();
        @(negedge clk);
        pop_s = pix_rd;
        @(posedge clk);
        #1;
        if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        fifo_q.delete();
        refresh_fifo();
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL reset_data got %h want 80", data_out); end
        checks++; if (pix_rd !== 1'b0) begin errors++; $display("FAIL reset_pix_rd got %b want 0", pix_rd); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_frames();
        logic [7:0] e;
        do_reset();
        load_fifo(8'h01, 32);
        enable = 1'b1;
        reset  = 1'b0;
        tick();
        checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL first_latency got %h want 80", data_out); end
        for (int s = 0; s < 140; s++) begin
            tick();
            e = exp_byte(s, fr_f(s / 60), (s >= 60) ? 8'h10 : 8'h00, 1'b0);
            checks++;
            if (data_out !== e) begin errors++; $display("FAIL frames_data s=%0d got %h want %h", s, data_out, e); end
            checks++;
            if (frame_start !== ((s % 60) == 0)) begin
                errors++; $display("FAIL frames_fs s=%0d got %b want %b", s, frame_start, (s % 60) == 0);
            end
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL frames_underrun got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        logic [7:0] e;
        do_reset();
        enable = 1'b1;
        reset  = 1'b0;
        tick();
        for (int s = 0; s < 60; s++) begin
            tick();
            e = exp_byte(s, 1'b0, 8'h00, 1'b1);
            checks++;
            if (data_out !== e) begin errors++; $display("FAIL urun_data s=%0d got %h want %h", s, data_out, e); end
            checks++;
            if (underrun !== (s >= 32)) begin errors++; $display("FAIL urun_flag s=%0d got %b want %b", s, underrun, s >= 32); end
        end
        tick();
        checks++; if (frame_start !== 1'b1 || data_out !== 8'hFF) begin
            errors++; $display("FAIL urun_period fs=%b data=%h want 1 FF", frame_start, data_out);
        end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_sticky got %b want 1", underrun); end
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_clear got %b want 0", underrun); end
        for (int s = 62; s < 92; s++) begin
            tick();
            e = exp_byte(s, fr_f(1), 8'h00, 1'b1);
            checks++;
            if (data_out !== e) begin errors++; $display("FAIL urun_data2 s=%0d got %h want %h", s, data_out, e); end
        end
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_clr_collision got %b want 1", underrun); end
        checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL urun_slot_fill got %h want 80", data_out); end
    endtask

    task automatic test_enable_drop();
        logic [7:0] e;
        do_reset();
        load_fifo(8'h01, 16);
        enable = 1'b1;
        reset  = 1'b0;
        tick();
        for (int s = 0; s < 60; s++) begin
            tick();
            e = exp_byte(s, 1'b0, 8'h00, 1'b0);
            checks++;
            if (data_out !== e) begin errors++; $display("FAIL drop_data s=%0d got %h want %h", s, data_out, e); end
            if (s == 25) enable = 1'b0;
        end
        for (int s = 60; s < 70; s++) begin
            tick();
            checks++;
            if (data_out !== 8'h80 || pix_rd !== 1'b0 || frame_start !== 1'b0) begin
                errors++; $display("FAIL drop_idle s=%0d data=%h rd=%b fs=%b want 80 0 0", s, data_out, pix_rd, frame_start);
            end
        end
        enable = 1'b1;
        tick();
        checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL restart_gap got %h want 80", data_out); end
        for (int s = 0; s < 4; s++) begin
            tick();
            e = exp_byte(s, fr_f(1), 8'h00, 1'b0);
            checks++;
            if (data_out !== e) begin errors++; $display("FAIL restart_data s=%0d got %h want %h", s, data_out, e); end
            if (s == 0) begin
                checks++;
                if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs got %b want 1", frame_start); end
            end
        end
    endtask

    task automatic test_reset_mid_sav();
        do_reset();
        enable = 1'b1;
        reset  = 1'b0;
        tick();
        for (int s = 0; s < 70; s++) tick();
        checks++; if (data_out !== 8'h00 || underrun !== 1'b1) begin
            errors++; $display("FAIL pre_reset_sav data=%h urun=%b want 00 1", data_out, underrun);
        end
        reset = 1'b1;
        tick();
        checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL midsav_data got %h want 80", data_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midsav_underrun got %b want 0", underrun); end
        checks++; if (frame_start !== 1'b0 || pix_rd !== 1'b0) begin
            errors++; $display("FAIL midsav_ctrl fs=%b rd=%b want 0 0", frame_start, pix_rd);
        end
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (data_out !== 8'h80) begin errors++; $display("FAIL midsav_no_xy i=%0d got %h want 80", i, data_out); end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        refresh_fifo();
        test_reset();
        test_frames();
        test_underrun();
        test_enable_drop();
        test_reset_mid_sav();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
